// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: ALU results pass straight to write-back; loads/stores go through a single-outstanding memory access.
// Latency: 1 cycle for non-memory ops; memory ops take 1 issue cycle plus the ACCESS cycles until mem_ready.
// Backpressure: freeze stalls upstream while a memop is issuing or waiting on mem_ready; no timeout.
module mem_wb_stage #(
    parameter int MEM_BASE = 1024,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_val_rm,
    input  logic [3:0]        in_dest,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_en,
    output logic [3:0]        wb_dest,
    output logic [31:0]       wb_value
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [ADDR_W+1:0] BASE_L = (ADDR_W+2)'(MEM_BASE);

    state_t              state_q, state_d;
    logic                h_we_q, h_we_d;
    logic [ADDR_W-1:0]   h_addr_q, h_addr_d;
    logic [31:0]         h_wdata_q, h_wdata_d;
    logic [3:0]          h_dest_q, h_dest_d;
    logic                h_wb_en_q, h_wb_en_d;
    logic                wb_en_q, wb_en_d;
    logic [3:0]          wb_dest_q, wb_dest_d;
    logic [31:0]         wb_value_q, wb_value_d;

    logic                memop;
    logic                addr_borrow;
    logic [ADDR_W-1:0]   word_addr;

    assign memop = in_valid & (in_mem_r_en | in_mem_w_en);

    // Only bits [ADDR_W+1:0] of the difference matter; the borrow out of the byte offset keeps it exact mod 2^32.
    assign addr_borrow = in_alu_result[1:0] < BASE_L[1:0];
    assign word_addr   = in_alu_result[ADDR_W+1:2] - BASE_L[ADDR_W+1:2]
                       - {{(ADDR_W-1){1'b0}}, addr_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop)     state_d = ACCESS;
            ACCESS:  if (mem_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            IDLE:    freeze = memop;
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = h_we_q;
                freeze  = ~mem_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        h_we_d     = h_we_q;
        h_addr_d   = h_addr_q;
        h_wdata_d  = h_wdata_q;
        h_dest_d   = h_dest_q;
        h_wb_en_d  = h_wb_en_q;
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        if (state_q == IDLE) begin
            if (memop) begin
                h_we_d    = in_mem_w_en;
                h_addr_d  = word_addr;
                h_wdata_d = in_val_rm;
                h_dest_d  = in_dest;
                h_wb_en_d = in_wb_en & ~in_mem_w_en;
            end else if (in_valid) begin
                wb_en_d    = in_wb_en;
                wb_dest_d  = in_dest;
                wb_value_d = in_alu_result;
            end
        end else if (mem_ready) begin
            // Held wb_en is already cleared for stores.
            wb_en_d = h_wb_en_q;
            if (!h_we_q) begin
                wb_dest_d  = h_dest_q;
                wb_value_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_we_q     <= 1'b0;
            h_addr_q   <= '0;
            h_wdata_q  <= '0;
            h_dest_q   <= '0;
            h_wb_en_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
        end else begin
            h_we_q     <= h_we_d;
            h_addr_q   <= h_addr_d;
            h_wdata_q  <= h_wdata_d;
            h_dest_q   <= h_dest_d;
            h_wb_en_q  <= h_wb_en_d;
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
        end
    end

    assign mem_addr  = h_addr_q;
    assign mem_wdata = h_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_dest   = wb_dest_q;
    assign wb_value  = wb_value_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level model compared every cycle, plus literal spot checks.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_wb_en = 1'b0, in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
    logic [31:0] in_alu_result = '0, in_val_rm = '0;
    logic [3:0]  in_dest = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        freeze, mem_req, mem_we, wb_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, wb_value;
    logic [3:0]  wb_dest;

    int vectors = 0;
    int miscompares = 0;

    mem_wb_stage #(.MEM_BASE(1024), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_alu_result(in_alu_result), .in_val_rm(in_val_rm), .in_dest(in_dest),
        .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  dest;
        logic        wben;
    } acc_t;

    // Model: queue of outstanding accesses (at most one) and the expected write-back register.
    acc_t        pend[$];
    logic        e_wb_en = 1'b0;
    logic [3:0]  e_wb_dest = '0;
    logic [31:0] e_wb_value = '0;

    acc_t        acc_log[$];
    logic [3:0]  wb_log[$];

    function automatic logic [15:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return 16'((off / 32'd4) % 32'd65536);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        acc_t a;
        if (rst) begin
            pend.delete();
            e_wb_en = 1'b0; e_wb_dest = '0; e_wb_value = '0;
        end else if (pend.size() != 0) begin
            e_wb_en = 1'b0;
            if (mem_ready) begin
                a = pend.pop_front();
                if (!a.we) begin
                    e_wb_en = a.wben; e_wb_dest = a.dest; e_wb_value = mem_rdata;
                end
            end
        end else if (in_valid && (in_mem_r_en || in_mem_w_en)) begin
            a.we = in_mem_w_en; a.addr = word_of(in_alu_result); a.wdata = in_val_rm;
            a.dest = in_dest; a.wben = in_wb_en & ~in_mem_w_en;
            pend.push_back(a);
            e_wb_en = 1'b0;
        end else if (in_valid) begin
            e_wb_en = in_wb_en; e_wb_dest = in_dest; e_wb_value = in_alu_result;
        end else begin
            e_wb_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic busy;
        busy = pend.size() != 0;
        chk("freeze", freeze, busy ? !mem_ready : (in_valid && (in_mem_r_en || in_mem_w_en)));
        chk("mem_req", mem_req, busy);
        chk("mem_we", mem_we, busy && pend[0].we);
        if (busy) begin
            chk("mem_addr", mem_addr, pend[0].addr);
            chk("mem_wdata", mem_wdata, pend[0].wdata);
        end
        chk("wb_en", wb_en, e_wb_en);
        chk("wb_dest", wb_dest, e_wb_dest);
        chk("wb_value", wb_value, e_wb_value);
    end

    always @(negedge clk) begin
        acc_t a;
        if (mem_req && mem_ready) begin
            a.we = mem_we; a.addr = mem_addr; a.wdata = mem_wdata; a.dest = '0; a.wben = 1'b0;
            acc_log.push_back(a);
        end
        if (wb_en) wb_log.push_back(wb_dest);
    end

    task automatic cyc(input logic v, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] d,
                       input logic rdy, input logic [31:0] rd);
        in_valid = v; in_wb_en = wb; in_mem_r_en = r; in_mem_w_en = w;
        in_alu_result = alu; in_val_rm = rm; in_dest = d;
        mem_ready = rdy; mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // ALU op
        cyc(1, 1, 0, 0, 32'h55, 0, 4'd3, 0, 0);
        chk("alu_wb_en", wb_en, 1);
        chk("alu_wb_dest", wb_dest, 3);
        chk("alu_wb_value", wb_value, 32'h55);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_pulse", wb_en, 0);

        // Load with three not-ready cycles
        cyc(1, 1, 1, 0, 32'd1028, 0, 4'd5, 0, 0);
        chk("ld_mem_req", mem_req, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 1);
        chk("ld_freeze", freeze, 1);
        repeat (3) cyc(1, 1, 1, 0, 32'd1028, 0, 4'd5, 0, 32'h1111_1111);
        cyc(1, 1, 1, 0, 32'd1028, 0, 4'd5, 1, 32'hDEADBEEF);
        chk("ld_wb_en", wb_en, 1);
        chk("ld_wb_dest", wb_dest, 5);
        chk("ld_wb_value", wb_value, 32'hDEADBEEF);
        chk("ld_req_drop", mem_req, 0);

        // Store with wb_en=1 still never writes back
        cyc(1, 1, 0, 1, 32'd1032, 32'h1234, 4'd7, 0, 0);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 2);
        chk("st_mem_wdata", mem_wdata, 32'h1234);
        cyc(1, 1, 0, 1, 32'd1032, 32'h1234, 4'd7, 1, 32'hFFFF_0000);
        chk("st_wb_en", wb_en, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_wb_en2", wb_en, 0);

        // Back-to-back load, store, ALU op
        acc_log.delete(); wb_log.delete();
        cyc(1, 1, 1, 0, 32'd1040, 0, 4'd2, 0, 0);
        cyc(1, 1, 1, 0, 32'd1040, 0, 4'd2, 1, 32'hA5A5_0001);
        cyc(1, 0, 0, 1, 32'd1044, 32'hCAFE, 4'd0, 0, 0);
        cyc(1, 0, 0, 1, 32'd1044, 32'hCAFE, 4'd0, 1, 0);
        cyc(1, 1, 0, 0, 32'h99, 0, 4'd9, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_accesses", acc_log.size(), 2);
        chk("b2b_pulses", wb_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("b2b_acc0_we", acc_log[0].we, 0);
            chk("b2b_acc0_addr", acc_log[0].addr, 4);
            chk("b2b_acc1_we", acc_log[1].we, 1);
            chk("b2b_acc1_addr", acc_log[1].addr, 5);
            chk("b2b_acc1_wdata", acc_log[1].wdata, 32'hCAFE);
        end
        if (wb_log.size() == 2) begin
            chk("b2b_wb0_dest", wb_log[0], 2);
            chk("b2b_wb1_dest", wb_log[1], 9);
        end

        // Reset in the middle of an access
        cyc(1, 1, 1, 0, 32'd1100, 0, 4'd4, 0, 0);
        chk("rst_pre_req", mem_req, 1);
        #2;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_wb_en", wb_en, 0);
        chk("arst_freeze", freeze, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_wb_value", wb_value, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b0;
        cyc(1, 1, 1, 0, 32'd1036, 0, 4'd6, 0, 0);
        chk("post_rst_addr", mem_addr, 3);
        cyc(1, 1, 1, 0, 32'd1036, 0, 4'd6, 1, 32'h0BAD_F00D);
        chk("post_rst_wb_en", wb_en, 1);
        chk("post_rst_wb_value", wb_value, 32'h0BAD_F00D);

        // Load request without in_valid is ignored
        cyc(0, 1, 1, 0, 32'd1028, 0, 4'd1, 0, 0);
        chk("nv_freeze", freeze, 0);
        chk("nv_mem_req", mem_req, 0);
        chk("nv_wb_en", wb_en, 0);

        // Both r_en and w_en: treated as store; address below MEM_BASE wraps
        cyc(1, 1, 1, 1, 32'd0, 32'h77, 4'd8, 0, 0);
        chk("rw_mem_we", mem_we, 1);
        chk("wrap_mem_addr", mem_addr, 16'hFF00);
        cyc(1, 1, 1, 1, 32'd0, 32'h77, 4'd8, 1, 32'h1);
        chk("rw_wb_en", wb_en, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
